// File: rtl/stage_sequencer.sv
// Multi-cycle stage sequencer: one-hot registered stage enables with per-instruction
// stage skipping, stall, flush and run/idle control.
module stage_sequencer #(
  parameter int NUM_STAGES = 5,
  parameter int COUNT_W    = 32,
  parameter int IDX_W      = $clog2(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [NUM_STAGES-1:0] stage_mask,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [IDX_W-1:0]      stage_idx,
  output logic                  busy,
  output logic                  instr_done,
  output logic [COUNT_W-1:0]    instr_count
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [NUM_STAGES-1:0] FIXED_STAGES = {{(NUM_STAGES-2){1'b0}}, 2'b11};

  state_t                  state_r;
  logic [NUM_STAGES-1:0]   stage_en_r;
  logic [IDX_W-1:0]        stage_idx_r;
  logic                    busy_r;
  logic                    instr_done_r;
  logic [COUNT_W-1:0]      count_r;
  logic [NUM_STAGES-1:0]   mask_r;

  logic [NUM_STAGES-1:0]   eff_mask_s;
  logic [IDX_W-1:0]        last_idx_s;
  logic [IDX_W-1:0]        next_idx_s;
  logic                    is_last_s;

  function automatic logic [IDX_W-1:0] highest_set(input logic [NUM_STAGES-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (m[i]) begin
        r = IDX_W'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] next_set(input logic [NUM_STAGES-1:0] m,
                                                input logic [IDX_W-1:0] s);
    logic [IDX_W-1:0] r;
    r = s;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (m[i] && (i > int'(s))) begin
        r = IDX_W'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  function automatic logic [NUM_STAGES-1:0] onehot(input logic [IDX_W-1:0] s);
    return NUM_STAGES'(1) << s;
  endfunction

  // Decode stage reads the fresh mask from decode; later stages use the latched copy.
  always_comb begin
    eff_mask_s = mask_r;
    if (stage_idx_r == IDX_W'(1)) begin
      eff_mask_s = stage_mask | FIXED_STAGES;
    end else begin
      eff_mask_s = mask_r;
    end
    last_idx_s = highest_set(eff_mask_s);
    next_idx_s = next_set(eff_mask_s, stage_idx_r);
    is_last_s  = (stage_idx_r == last_idx_s);
  end

  // Sequencer state machine with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      stage_en_r   <= '0;
      stage_idx_r  <= '0;
      busy_r       <= 1'b0;
      instr_done_r <= 1'b0;
      count_r      <= '0;
      mask_r       <= '1;
    end else begin
      case (state_r)
        IDLE: begin
          instr_done_r <= 1'b0;
          stage_idx_r  <= '0;
          if (run) begin
            state_r    <= RUN;
            stage_en_r <= onehot(IDX_W'(0));
            busy_r     <= 1'b1;
          end else begin
            stage_en_r <= '0;
            busy_r     <= 1'b0;
          end
        end
        RUN: begin
          if (flush) begin
            instr_done_r <= 1'b0;
            mask_r       <= '1;
            stage_idx_r  <= '0;
            if (run) begin
              stage_en_r <= onehot(IDX_W'(0));
              busy_r     <= 1'b1;
            end else begin
              state_r    <= IDLE;
              stage_en_r <= '0;
              busy_r     <= 1'b0;
            end
          end else if (stall) begin
            instr_done_r <= 1'b0;
          end else begin
            if (stage_idx_r == IDX_W'(1)) begin
              mask_r <= eff_mask_s;
            end else begin
              mask_r <= mask_r;
            end
            if (is_last_s) begin
              instr_done_r <= 1'b1;
              count_r      <= count_r + COUNT_W'(1);
              stage_idx_r  <= '0;
              if (run) begin
                stage_en_r <= onehot(IDX_W'(0));
                busy_r     <= 1'b1;
              end else begin
                state_r    <= IDLE;
                stage_en_r <= '0;
                busy_r     <= 1'b0;
              end
            end else begin
              instr_done_r <= 1'b0;
              stage_idx_r  <= next_idx_s;
              stage_en_r   <= onehot(next_idx_s);
              busy_r       <= 1'b1;
            end
          end
        end
        default: begin
          state_r      <= IDLE;
          stage_en_r   <= '0;
          stage_idx_r  <= '0;
          busy_r       <= 1'b0;
          instr_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign stage_en    = stage_en_r;
  assign stage_idx   = stage_idx_r;
  assign busy        = busy_r;
  assign instr_done  = instr_done_r;
  assign instr_count = count_r;

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer: stimulus queues hand-computed per-cycle
// expectations, a negedge monitor compares whenever the DUT is busy or retiring.
module tb_stage_sequencer;

  localparam int NS = 5;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          run;
  logic          stall;
  logic          flush;
  logic [NS-1:0] stage_mask;
  logic [NS-1:0] stage_en;
  logic [2:0]    stage_idx;
  logic          busy;
  logic          instr_done;
  logic [CW-1:0] instr_count;

  typedef struct packed {
    logic [NS-1:0] en;
    logic [2:0]    idx;
    logic          done;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;

  stage_sequencer #(.NUM_STAGES(NS), .COUNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .stall       (stall),
    .flush       (flush),
    .stage_mask  (stage_mask),
    .stage_en    (stage_en),
    .stage_idx   (stage_idx),
    .busy        (busy),
    .instr_done  (instr_done),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Push the expectation for the cycle after the next edge, then take that edge.
  task automatic cyc(input logic [NS-1:0] en, input logic [2:0] idx,
                     input logic done, input logic [CW-1:0] cnt);
    exp_t e;
    e.en = en; e.idx = idx; e.done = done; e.cnt = cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop and compare whenever the DUT shows an active stage or a retire pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (busy || instr_done)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: actual en=%b idx=%0d done=%b cnt=%0d required no output",
                 stage_en, stage_idx, instr_done, instr_count);
      end else begin
        e = exp_q.pop_front();
        if (stage_en !== e.en || stage_idx !== e.idx || instr_done !== e.done ||
            instr_count !== e.cnt || busy !== (|e.en)) begin
          n_fail++;
          $display("FAIL cycle_output: actual en=%b idx=%0d done=%b cnt=%0d busy=%b required en=%b idx=%0d done=%b cnt=%0d busy=%b",
                   stage_en, stage_idx, instr_done, instr_count, busy,
                   e.en, e.idx, e.done, e.cnt, |e.en);
        end
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b1; run = 1'b0; stall = 1'b0; flush = 1'b0; stage_mask = 5'b00000;
    #1 rst_n = 1'b0;
    #1;
    check("reset_stage_en", 32'(stage_en), 32'd0);
    check("reset_stage_idx", 32'(stage_idx), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_instr_done", 32'(instr_done), 32'd0);
    check("reset_instr_count", 32'(instr_count), 32'd0);
    idle_step();
    rst_n = 1'b1;
    idle_step();

    // Full mask, then a 10011 instruction back to back.
    run = 1'b1; stage_mask = 5'b11111;
    cyc(5'b00001, 3'd0, 1'b0, 4'd0);
    cyc(5'b00010, 3'd1, 1'b0, 4'd0);
    cyc(5'b00100, 3'd2, 1'b0, 4'd0);
    cyc(5'b01000, 3'd3, 1'b0, 4'd0);
    cyc(5'b10000, 3'd4, 1'b0, 4'd0);
    stage_mask = 5'b10011;
    cyc(5'b00001, 3'd0, 1'b1, 4'd1);
    cyc(5'b00010, 3'd1, 1'b0, 4'd1);
    cyc(5'b10000, 3'd4, 1'b0, 4'd1);
    stage_mask = 5'b11111;
    cyc(5'b00001, 3'd0, 1'b1, 4'd2);

    // Stall three cycles in stage 2.
    cyc(5'b00010, 3'd1, 1'b0, 4'd2);
    cyc(5'b00100, 3'd2, 1'b0, 4'd2);
    stall = 1'b1;
    repeat (3) cyc(5'b00100, 3'd2, 1'b0, 4'd2);
    stall = 1'b0;
    cyc(5'b01000, 3'd3, 1'b0, 4'd2);
    cyc(5'b10000, 3'd4, 1'b0, 4'd2);
    cyc(5'b00001, 3'd0, 1'b1, 4'd3);

    // Flush together with stall in stage 3.
    cyc(5'b00010, 3'd1, 1'b0, 4'd3);
    cyc(5'b00100, 3'd2, 1'b0, 4'd3);
    cyc(5'b01000, 3'd3, 1'b0, 4'd3);
    flush = 1'b1; stall = 1'b1;
    cyc(5'b00001, 3'd0, 1'b0, 4'd3);
    flush = 1'b0; stall = 1'b0;

    // Drop run in stage 1: instruction completes, then idle.
    stage_mask = 5'b10111;
    cyc(5'b00010, 3'd1, 1'b0, 4'd3);
    run = 1'b0;
    cyc(5'b00100, 3'd2, 1'b0, 4'd3);
    cyc(5'b10000, 3'd4, 1'b0, 4'd3);
    cyc(5'b00000, 3'd0, 1'b1, 4'd4);
    idle_step();
    idle_step();
    check("idle_stage_en", 32'(stage_en), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    run = 1'b1;
    cyc(5'b00001, 3'd0, 1'b0, 4'd4);

    // Minimal 2-cycle instructions until the 4-bit counter wraps.
    stage_mask = 5'b00000;
    for (int k = 1; k <= 13; k++) begin
      cyc(5'b00010, 3'd1, 1'b0, 4'(3 + k));
      cyc(5'b00001, 3'd0, 1'b1, 4'(4 + k));
    end
    #3;
    check("count_after_17_retires", 32'(instr_count), 32'd1);

    // Flush on the retire edge: no retire.
    cyc(5'b00010, 3'd1, 1'b0, 4'd1);
    flush = 1'b1;
    cyc(5'b00001, 3'd0, 1'b0, 4'd1);
    flush = 1'b0;

    // Asynchronous reset mid-stall.
    stage_mask = 5'b11111;
    cyc(5'b00010, 3'd1, 1'b0, 4'd1);
    cyc(5'b00100, 3'd2, 1'b0, 4'd1);
    stall = 1'b1;
    cyc(5'b00100, 3'd2, 1'b0, 4'd1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_stage_en", 32'(stage_en), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_instr_count", 32'(instr_count), 32'd0);
    stall = 1'b0; run = 1'b0;
    idle_step();
    idle_step();
    rst_n = 1'b1;
    idle_step();
    idle_step();
    check("post_reset_idle_en", 32'(stage_en), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Parametrised multi-cycle stage sequencer, successor to the fixed four-stage scheduler in the processor top. It produces single-cycle-qualified, one-hot stage enables, so datapath blocks run on the common clock and are no longer clocked by stage bits. Each instruction can skip stages through a per-instruction stage mask, and the sequencer accepts stall, flush and run/idle control. It sits between the decode logic and every stage-gated block (memory, instruction register, register file, program counter).

## Interface
- NUM_STAGES, 5, number of pipeline-less stages per instruction; legal range 3..16; stage 0 = fetch, stage 1 = decode.
- COUNT_W, 32, width of the retired-instruction counter.
- IDX_W, $clog2(NUM_STAGES), derived width of stage_idx; not overridden.

- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- run  input  1  level; 1 = keep issuing instructions, 0 = go idle at the next instruction boundary.
- stall  input  1  level; 1 = hold the current stage (memory or peripheral not ready).
- flush  input  1  1-cycle pulse; abort the current instruction and restart at stage 0 (PC redirect).
- stage_mask  input  NUM_STAGES  per-instruction active stages from decode; bits 0 and 1 are ignored and always treated as 1.
- stage_en  output  NUM_STAGES  one-hot enable of the current stage; all zero when idle.
- stage_idx  output  IDX_W  binary index of the current stage; 0 when idle.
- busy  output  1  1 while any stage is active.
- instr_done  output  1  1-cycle pulse when an instruction retires.
- instr_count  output  COUNT_W  number of retired instructions; wraps modulo 2^COUNT_W.

## Operation
- States: IDLE and RUN. In RUN, the current stage s is held in stage_idx, and stage_en is the one-hot encoding of s.
- Reset values: state IDLE, stage_en 0, stage_idx 0, busy 0, instr_done 0, instr_count 0, and the latched mask all ones.
- IDLE: if run=1, enter RUN at stage 0 on the next edge. Otherwise remain in IDLE. stall and flush are ignored in IDLE.
- Advance priority in RUN, evaluated each edge:
  1. flush=1: go to stage 0 if run=1, else IDLE. No instr_done, no count update, and the latched mask is reset to all ones.
  2. Else if stall=1: hold s. Outputs stay unchanged.
  3. Else if s is the last active stage: retire. Pulse instr_done, increment instr_count, then go to stage 0 if run=1, else IDLE.
  4. Else: go to the lowest index greater than s whose latched-mask bit is 1.
- Mask latching: stage_mask is captured when leaving stage 1 through rule 4 or rule 3. The next stage is chosen from the incoming stage_mask value on that same edge. Bits 0 and 1 are forced to 1.
- Last active stage: the highest set bit of the effective mask. If the mask bits above 1 are all zero, stage 1 is the last active stage and the instruction retires after decode.
- run is sampled only at retire, and by the flush rule when flush=1. Dropping run mid-instruction never truncates the instruction.
- busy equals |stage_en.
- instr_count wraps from 2^COUNT_W-1 to 0 without any flag.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- Minimum instruction: 2 cycles (stages 0 and 1). Full mask: NUM_STAGES cycles. Each stall cycle adds one cycle.
- From IDLE with run=1 at edge k: stage_en[0]=1 in the cycle after edge k.
- Retire at edge k: during the cycle following edge k, instr_done=1 and instr_count is already incremented. Also during that cycle, stage_en[0]=1 if run=1 at edge k, else all zeros.
- Back-to-back instructions have no bubble.
- flush and stall on the same edge: flush wins.
- flush on the retire edge: flush wins. No retire, no count update.
- rst_n low at any time forces reset values immediately (asynchronously), including mid-stall. Release is synchronous to the next clk edge.

## Test plan
- Reset then run=1, stage_mask=5'b11111, no stall: stage_en sequence 00001,00010,00100,01000,10000,00001. instr_done pulses in the cycle showing the second 00001. instr_count=1.
- stage_mask=5'b10011 (skip stages 2 and 3): stage_en sequence 00001,00010,10000, then retire. A 3-cycle instruction. stage_idx sequence 0,1,4.
- stall held 3 cycles while in stage 2: stage_en=00100 for 4 cycles total, then advances. Instruction takes 8 cycles. instr_count increments exactly once.
- flush asserted in stage 3 together with stall=1: the next cycle shows stage_en=00001 with no instr_done pulse, and instr_count is unchanged.
- run dropped during stage 1: the instruction completes all masked stages, then stage_en=0, busy=0 and the sequencer stays idle. Re-asserting run restarts at stage 0 one cycle later.
- COUNT_W=4, retire 17 instructions: instr_count reads 0 after the 16th retire and 1 after the 17th. rst_n pulsed low mid-instruction: all outputs are 0 immediately.
